fifo_rd_stream: RTL and testbench

Read-side drain engine for the asynchronous FIFO, running entirely in the read clock domain. It issues pops on the FIFO read port (`rd_en` / `data_out` / `FIFO_empty`), absorbs the FIFO's one-cycle registered read latency, and presents the words on a valid/ready stream with a 2-entry buffer. Sustained throughput is one word per cycle, and no word is ever lost or duplicated under downstream backpressure.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/skid_buf2.sv | 78 +++++++
 rtl/fifo_rd_stream.sv | 82 ++++++++
 tb/tb_fifo_rd_stream.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO read-side logic.
//   FIFO_WIDTH   : default data word width (must match the FIFO's width)
//   RD_BUF_DEPTH : number of entries in the read-side stream buffer
//   occ_t        : occupancy encoding of the read-side stream buffer
package fifo_pkg;

    localparam int FIFO_WIDTH   = 4;
    localparam int RD_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2
// Two-entry shift buffer, head first. A push and a pop in the same
// cycle shift the head out and write the new word into the freed slot.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write din into the first free slot (after any pop shift)
//   pop        : drop the head entry
//   flush      : discard all entries (takes priority over push/pop)
//   din        : word to write
//   head       : current head entry
//   occ        : occupancy, EMPTY / ONE / TWO
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output occ_t             occ
);

    logic [WIDTH-1:0] buf_q [RD_BUF_DEPTH];
    occ_t             occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (flush) begin
            // Stale data stays in the slots; occupancy alone marks them dead.
            occ_q <= OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    // A pop cannot occur here: the head is not valid.
                    if (push) begin
                        buf_q[0] <= din;
                        occ_q    <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b11: buf_q[0] <= din;
                        2'b10: begin
                            buf_q[1] <= din;
                            occ_q    <= OCC_TWO;
                        end
                        2'b01: occ_q <= OCC_EMPTY;
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // Push without pop is excluded upstream by the issue credit.
                    if (pop) begin
                        buf_q[0] <= buf_q[1];
                        if (push) begin
                            buf_q[1] <= din;
                        end else begin
                            occ_q <= OCC_ONE;
                        end
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

    assign head = buf_q[0];
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-domain drain engine: pops the FIFO, absorbs its one-cycle read
// latency and presents words on a valid/ready stream through a 2-entry
// buffer. One word per cycle sustained; nothing lost under backpressure.
// Ports:
//   clk_r, reset_n : read clock, asynchronous active-low reset
//   flush          : drop buffered and in-flight words
//   fifo_empty     : FIFO empty flag
//   fifo_data      : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en     : pop request to the FIFO
//   m_valid/m_ready/m_data : output stream
//   rd_count       : words delivered on the stream, wrapping
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int width     = FIFO_WIDTH,
    parameter int cnt_width = 16
) (
    input  logic                 clk_r,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [width-1:0]     fifo_data,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [width-1:0]     m_data,
    output logic [cnt_width-1:0] rd_count
);

    occ_t                 occ;
    logic                 inflight_q;
    logic                 inflight_d;
    logic [cnt_width-1:0] rd_count_q;
    logic [cnt_width-1:0] rd_count_d;
    logic                 pop;
    logic                 capture;
    logic [2:0]           credit;

    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;
    assign capture = inflight_q & ~flush;

    // Slots that will still be committed after this cycle: buffered words
    // plus the word in flight, less the one leaving now. Issuing only while
    // this is below the buffer depth means a capture always has a free slot.
    assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    // reset_n is in the term so the pop request is low for the whole time
    // reset is held, not just from the first edge.
    assign fifo_rd_en = reset_n & ~fifo_empty & ~flush
                      & (credit < 3'(RD_BUF_DEPTH));

    assign inflight_d = fifo_rd_en;
    assign rd_count_d = pop ? rd_count_q + 1'b1 : rd_count_q;

    always_ff @(posedge clk_r or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;

    skid_buf2 #(
        .WIDTH (width)
    ) u_buf (
        .clk   (clk_r),
        .rst_n (reset_n),
        .push  (capture),
        .pop   (pop),
        .flush (flush),
        .din   (fifo_data),
        .head  (m_data),
        .occ   (occ)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Directed and random stimulus for fifo_rd_stream. A queue stands in for
// the FIFO; the reference keeps the words popped from it and not yet
// delivered or flushed, in order, and derives the stream outputs from that.
module tb_fifo_rd_stream;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [15:0]  rd_count;

    logic         fifo_rd_en4;
    logic         m_valid4;
    logic [W-1:0] m_data4;
    logic [3:0]   rd_count4;

    fifo_rd_stream #(.width(W), .cnt_width(16)) dut (
        .clk_r      (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .rd_count   (rd_count)
    );

    // Narrow-counter copy fed the same inputs, for the wrap check.
    fifo_rd_stream #(.width(W), .cnt_width(4)) dut4 (
        .clk_r      (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en4),
        .m_valid    (m_valid4),
        .m_ready    (m_ready),
        .m_data     (m_data4),
        .rd_count   (rd_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] fifo_q [$];   // words still in the FIFO
    logic [W-1:0] exp_q  [$];   // words popped, not yet delivered/flushed
    bit           inflight_m = 1'b0;
    int           cnt      = 0;
    int           n_issued = 0;
    int           n_deliv  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n, input logic [W-1:0] start);
        for (int i = 0; i < n; i++) fifo_q.push_back(start + W'(i));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // One clock: check outputs at the falling edge, update the model
    // just after the rising edge. Returns at posedge + 1.
    task automatic cycle();
        int   sz;
        int   after;
        bit   exp_valid;
        bit   exp_rd;
        bit   pop_s;
        bit   rd_s;
        bit   fl_s;
        logic [W-1:0] w;
        @(negedge clk);
        sz        = exp_q.size();
        exp_valid = (sz - int'(inflight_m)) > 0;
        pop_s     = exp_valid && m_ready;
        exp_rd    = !fifo_empty && !flush && ((sz - int'(pop_s)) < 2);
        check("m_valid", m_valid, exp_valid);
        if (exp_valid) check("m_data", m_data, exp_q[0]);
        check("fifo_rd_en", fifo_rd_en, exp_rd);
        check("rd_count", rd_count, cnt[15:0]);
        check("rd_count_w4", rd_count4, cnt[3:0]);
        rd_s  = fifo_rd_en;
        fl_s  = flush;
        after = sz - int'(pop_s) + int'(rd_s);
        check("credit_bound", after <= 2, 1);
        if (rd_s) n_issued++;
        @(posedge clk);
        #1;
        if (pop_s) begin
            void'(exp_q.pop_front());
            cnt++;
            n_deliv++;
        end
        if (fl_s) exp_q.delete();
        inflight_m = rd_s && !fl_s;
        if (rd_s && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            fifo_data = w;
            if (!fl_s) exp_q.push_back(w);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i0;
        int d0;
        int c0;
        reset_n    = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b1;
        fifo_data  = '0;
        fifo_empty = 1'b1;

        // Reset state, with words waiting so fifo_rd_en must be held low by reset.
        load(5, 8'h01);
        #12;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Burst of 5 with the consumer always ready.
        i0 = n_issued;
        repeat (9) cycle();
        check("burst_issued", n_issued - i0, 5);
        check("burst_delivered", n_deliv, 5);
        check("burst_rd_count", rd_count, 5);

        // Backpressure: only two words may be taken while stalled.
        m_ready = 1'b0;
        load(8, 8'h10);
        i0 = n_issued;
        repeat (6) cycle();
        check("bp_issued", n_issued - i0, 2);
        check("bp_head", m_data, 8'h10);
        m_ready = 1'b1;
        d0 = n_deliv;
        repeat (12) cycle();
        check("bp_delivered", n_deliv - d0, 8);

        // Random 30% ready over 200 words.
        load(200, 8'h20);
        d0 = n_deliv;
        for (int k = 0; k < 4000 && (n_deliv - d0) < 200; k++) begin
            m_ready = ($urandom_range(99) < 30);
            cycle();
        end
        check("rand_delivered", n_deliv - d0, 200);
        m_ready = 1'b0;
        repeat (3) cycle();

        // Flush with one word buffered and one in flight.
        load(2, 8'hA0);
        repeat (2) cycle();
        c0 = cnt;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_valid", m_valid, 0);
        check("flush_rd_count", rd_count, c0);
        load(1, 8'hA2);
        m_ready = 1'b1;
        d0 = n_deliv;
        repeat (5) cycle();
        check("flush_next", n_deliv - d0, 1);

        // Asynchronous reset while the buffer is full.
        m_ready = 1'b0;
        load(4, 8'hB0);
        repeat (3) cycle();
        check("pre_rst_occ_two", m_data, 8'hB0);
        m_ready = 1'b1;
        #1;
        check("pre_rst_rd_en", fifo_rd_en, 1);
        #1 reset_n = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_m_data", m_data, 0);
        check("arst_rd_count", rd_count, 0);
        check("arst_fifo_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        inflight_m = 1'b0;
        cnt        = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) cycle();
        check("post_rst_count", rd_count, 2);

        // 4-bit counter passes 15 -> 0 -> 1 during these 17 words.
        load(17, 8'hC0);
        repeat (25) cycle();
        check("wrap_rd_count4", rd_count4, 4'd3);
        check("wrap_rd_count16", rd_count, 19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
